// File: rtl/adxl362_pkg.sv
// rtl/adxl362_pkg.sv - shared ADXL362 command codes and controller state encoding
//
// Purpose : constants and types shared by the ADXL362 SPI controller.
// Contents: WRITE_COMMAND / READ_COMMAND / FIFO_COMMAND opcodes, state_t FSM encoding.
package adxl362_pkg;

   localparam logic [7:0] WRITE_COMMAND = 8'h0A;
   localparam logic [7:0] READ_COMMAND  = 8'h0B;
   localparam logic [7:0] FIFO_COMMAND  = 8'h0D;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SCLK_LOW,
      SCLK_HIGH,
      CS_HOLD,
      CS_IDLE
   } state_t;

endpackage

// File: rtl/adxl362_controller.sv
// rtl/adxl362_controller.sv - SPI mode-0 main controller for ADXL362 register transactions
//
// Purpose : runs one 3-byte transaction (command, address, data) per start request.
// Ports   :
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               begin a transaction (only honoured while busy=0)
//   write               1 = register write (0x0A), 0 = register read (0x0B)
//   address             register address
//   data_to_send        write data (reads send 0x00)
//   data_received       last byte shifted in from MISO, updated at transaction end
//   busy                transaction in progress
//   done                one-cycle pulse when the transaction finishes
//   SPI_SCLK/MOSI/CS    registered SPI outputs (SCLK idles low, CS active-low)
//   SPI_MISO            SPI data in, sampled on the SCLK rising edge
module adxl362_controller
   import adxl362_pkg::*;
#(
   parameter int CLK_FREQUENCY  = 100_000_000,
   parameter int SCLK_FREQUENCY = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       write,
   input  logic [7:0] address,
   input  logic [7:0] data_to_send,
   output logic [7:0] data_received,
   output logic       busy,
   output logic       done,
   output logic       SPI_SCLK,
   output logic       SPI_MOSI,
   input  logic       SPI_MISO,
   output logic       SPI_CS
);

   localparam int HALF = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);

   if (HALF < 2) begin : g_bad_half
      $fatal(1, "adxl362_controller: CLK_FREQUENCY/(2*SCLK_FREQUENCY) must be at least 2");
   end

   // The CS-high gap is the longest phase (a full SCLK period plus one cycle),
   // which frames every transaction as 51 half-periods plus one cycle.
   localparam int             TW       = $clog2(2 * HALF + 1);
   localparam logic [TW-1:0]  HALF_END = TW'(HALF - 1);
   localparam logic [TW-1:0]  IDLE_END = TW'(2 * HALF);

   state_t        state;
   logic [TW-1:0] timer;
   logic [4:0]    bit_cnt;
   logic [23:0]   tx_shift;
   logic [7:0]    rx_shift;
   logic [23:0]   frame;
   logic          phase_end;

   assign frame = {write ? WRITE_COMMAND : READ_COMMAND,
                   address,
                   write ? data_to_send : 8'h00};

   assign phase_end = (state == CS_IDLE) ? (timer == IDLE_END) : (timer == HALF_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         timer         <= '0;
         bit_cnt       <= '0;
         tx_shift      <= '0;
         rx_shift      <= '0;
         data_received <= 8'h00;
         busy          <= 1'b0;
         done          <= 1'b0;
         SPI_SCLK      <= 1'b0;
         SPI_MOSI      <= 1'b0;
         SPI_CS        <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tx_shift <= frame;
                  SPI_MOSI <= frame[23];
                  SPI_CS   <= 1'b0;
                  busy     <= 1'b1;
                  timer    <= '0;
                  bit_cnt  <= '0;
                  state    <= CS_SETUP;
               end
            end

            CS_SETUP, SCLK_LOW: begin
               if (phase_end) begin
                  // MISO has been stable through the low phase; capture it as SCLK rises.
                  timer    <= '0;
                  SPI_SCLK <= 1'b1;
                  rx_shift <= {rx_shift[6:0], SPI_MISO};
                  state    <= SCLK_HIGH;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            SCLK_HIGH: begin
               if (phase_end) begin
                  timer    <= '0;
                  SPI_SCLK <= 1'b0;
                  if (bit_cnt < 5'd23) begin
                     tx_shift <= {tx_shift[22:0], 1'b0};
                     SPI_MOSI <= tx_shift[22];
                     bit_cnt  <= bit_cnt + 5'd1;
                     state    <= SCLK_LOW;
                  end else begin
                     state <= CS_HOLD;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            CS_HOLD: begin
               if (phase_end) begin
                  timer         <= '0;
                  SPI_CS        <= 1'b1;
                  data_received <= rx_shift;
                  state         <= CS_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            CS_IDLE: begin
               if (phase_end) begin
                  timer <= '0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adxl362_controller.sv
// tb/tb_adxl362_controller.sv - directed self-checking bench for adxl362_controller
module tb_adxl362_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, write;
   logic [7:0] address, data_to_send, data_received;
   logic       busy, done, sclk, mosi, miso, cs;

   logic       s2_start, s2_write, s2_busy, s2_done, s2_sclk, s2_mosi, s2_cs;
   logic       s2_miso;
   logic [7:0] s2_address, s2_data_to_send, s2_data_received;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   adxl362_controller dut (
      .clk(clk), .rst_n(rst_n), .start(start), .write(write), .address(address),
      .data_to_send(data_to_send), .data_received(data_received), .busy(busy), .done(done),
      .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_CS(cs)
   );

   adxl362_controller #(.CLK_FREQUENCY(100_000_000), .SCLK_FREQUENCY(5_000_000)) dut_fast (
      .clk(clk), .rst_n(rst_n), .start(s2_start), .write(s2_write), .address(s2_address),
      .data_to_send(s2_data_to_send), .data_received(s2_data_received), .busy(s2_busy),
      .done(s2_done), .SPI_SCLK(s2_sclk), .SPI_MOSI(s2_mosi), .SPI_MISO(s2_miso), .SPI_CS(s2_cs)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accelerometer slave model: shifts MOSI on SCLK rise, echoes the address in the third byte.
   logic [23:0] sl_shift = '0;
   logic [23:0] sl_frame = '0;
   logic [7:0]  sl_addr  = '0;
   int          sl_bits  = 0;
   int          sl_frame_bits = 0;

   always @(posedge sclk or negedge cs) begin
      if (!sclk) sl_bits = 0;
      else if (!cs) begin
         sl_shift = {sl_shift[22:0], mosi};
         sl_bits++;
         if (sl_bits == 16) sl_addr = sl_shift[7:0];
      end
   end

   always @(negedge sclk or negedge cs) begin
      if (!cs && sl_bits >= 16 && sl_bits < 24) miso = sl_addr[23 - sl_bits];
      else miso = 1'b0;
   end

   always @(posedge cs) begin
      sl_frame      = sl_shift;
      sl_frame_bits = sl_bits;
   end

   // Activity monitors; the bench only ever reads deltas of these.
   int sclk_rises = 0, sclk_cs_high = 0, done_pulses = 0, cs_hi_run = 0, cs_hi_last = 0;
   always @(posedge sclk) begin
      sclk_rises++;
      if (cs) sclk_cs_high++;
   end
   always @(posedge clk) begin
      if (done) done_pulses++;
      if (cs) cs_hi_run++;
      else begin
         if (cs_hi_run > 0) cs_hi_last = cs_hi_run;
         cs_hi_run = 0;
      end
   end

   task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input bit hold, output int cyc);
      @(negedge clk);
      write = w; address = a; data_to_send = d; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      cyc = 0;
      while (!done && cyc < 6000) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   initial begin
      int cyc, r0, d0, bad0, n, hi, lo, first_hi, first_lo;
      bit seen_hi;
      rst_n = 1'b0; start = 0; write = 0; address = 0; data_to_send = 0;
      s2_start = 0; s2_write = 0; s2_address = 0; s2_data_to_send = 0; s2_miso = 0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_cs",   cs,   1);
      check_eq("reset_sclk", sclk, 0);
      check_eq("reset_mosi", mosi, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_rx",   data_received, 8'h00);
      @(negedge clk); rst_n = 1'b1;

      // Register write 0x02 to 0x2D
      r0 = sclk_rises; d0 = done_pulses; bad0 = sclk_cs_high;
      run_txn(1'b1, 8'h2D, 8'h02, 0, cyc);
      check_eq("wr_latency", cyc, 2551);
      repeat (5) @(posedge clk); #1;
      $display("model: %s operation, Address 0x%h, Received Value 0x%h",
               sl_frame[23:16] == 8'h0A ? "Write" : "Read", sl_frame[15:8], sl_frame[7:0]);
      check_eq("wr_frame", sl_frame, 24'h0A2D02);
      check_eq("wr_sclk_rises", sclk_rises - r0, 24);
      check_eq("wr_done_count", done_pulses - d0, 1);
      check_eq("wr_sclk_cs_high", sclk_cs_high - bad0, 0);

      // Register read of 0x0F; model echoes the address
      run_txn(1'b0, 8'h0F, 8'hFF, 0, cyc);
      check_eq("rd_latency", cyc, 2551);
      check_eq("rd_data", data_received, 8'h0F);
      check_eq("rd_busy_at_done", busy, 0);
      repeat (2) @(posedge clk); #1;
      check_eq("rd_frame", sl_frame, 24'h0B0F00);

      // Back-to-back reads with start held high
      run_txn(1'b0, 8'h00, 8'h00, 1, cyc);
      check_eq("b2b_first_data", data_received, 8'h00);
      run_txn(1'b0, 8'hA5, 8'h00, 0, cyc);
      check_eq("b2b_second_latency", cyc, 2551);
      check_eq("b2b_cs_gap_ok", cs_hi_last >= 50, 1);
      check_eq("b2b_second_data", data_received, 8'hA5);
      repeat (2) @(posedge clk); #1;
      check_eq("b2b_busy_idle", busy, 0);

      // start pulse during a transaction must be ignored
      d0 = done_pulses; r0 = sclk_rises;
      fork
         run_txn(1'b0, 8'h0F, 8'h00, 0, cyc);
         begin
            repeat (500) @(negedge clk);
            address = 8'h33; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      repeat (300) @(posedge clk); #1;
      check_eq("busy_start_data", data_received, 8'h0F);
      check_eq("busy_start_frame", sl_frame, 24'h0B0F00);
      check_eq("busy_start_done_count", done_pulses - d0, 1);
      check_eq("busy_start_rises", sclk_rises - r0, 24);

      // Asynchronous reset after the 10th SCLK rising edge
      r0 = sclk_rises; d0 = done_pulses;
      @(negedge clk);
      write = 1'b1; address = 8'h2D; data_to_send = 8'h77; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (sclk_rises - r0 < 10 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("abort_reached_edge10", sclk_rises - r0, 10);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_cs",   cs,   1);
      check_eq("abort_sclk", sclk, 0);
      check_eq("abort_busy", busy, 0);
      repeat (20) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      check_eq("abort_no_done", done_pulses - d0, 0);

      run_txn(1'b1, 8'h1F, 8'h52, 0, cyc);
      check_eq("post_abort_latency", cyc, 2551);
      repeat (2) @(posedge clk); #1;
      check_eq("post_abort_frame", sl_frame, 24'h0A1F52);

      // Faster SCLK instance: HALF = 10
      @(negedge clk);
      s2_write = 1'b0; s2_address = 8'h11; s2_start = 1'b1;
      @(posedge clk); #1; s2_start = 1'b0;
      n = 0; hi = 0; lo = 0; first_hi = -1; first_lo = -1; seen_hi = 0;
      while (!s2_done && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (s2_sclk) begin
            hi++;
            if (lo > 0 && first_lo < 0) first_lo = lo;
            lo = 0;
            seen_hi = 1;
         end else begin
            if (hi > 0 && first_hi < 0) first_hi = hi;
            hi = 0;
            if (seen_hi) lo++;
         end
      end
      check_eq("fast_latency", n, 511);
      check_eq("fast_high_phase", first_hi, 10);
      check_eq("fast_low_phase", first_lo, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
